// File: rtl/wb_pkg.sv
// Shared writeback types: queued-result record, drain phase enum and the
// default datapath widths used by the ALU, writeback and register-file blocks.
package wb_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 5;

    typedef enum logic {
        S_LO = 1'b0,
        S_HI = 1'b1
    } wb_phase_t;

    typedef struct packed {
        logic [2*WB_DATA_W-1:0] result;
        logic [WB_ADDR_W-1:0]   rdst1;
        logic [WB_ADDR_W-1:0]   rdst2;
        logic                   wide;
        logic                   we;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is a combinational read of the
// oldest entry so a push is visible to the consumer on the very next cycle.
module wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wptr;
    logic [PTR_W:0]   r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Same index with opposite wrap bits means the writer has lapped the reader.
    assign o_full    = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                       (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign o_head    = r_mem[r_rptr[PTR_W-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
    end

endmodule

// File: rtl/writeback_sequencer.sv
// Writeback sequencer: queues ALU results and drains them through the single
// register-file write port. Optional macro WB_R0_DISCARD_EN suppresses writes to R0.
module writeback_sequencer
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DATA_W-1:0] in_result,
    input  logic [ADDR_W-1:0]   in_rdst1,
    input  logic [ADDR_W-1:0]   in_rdst2,
    input  logic                in_wide,
    input  logic                in_we,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                busy,
    output logic [15:0]         wb_count
);

    wb_entry_t                 w_in_entry;
    wb_entry_t                 w_head;
    logic [$bits(wb_entry_t)-1:0] w_head_bits;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_we_raw;
    logic                      w_we;
    logic [ADDR_W-1:0]         w_waddr;
    logic [DATA_W-1:0]         w_wdata;

    wb_phase_t                 r_phase;
    logic [15:0]               r_count;
    logic [ADDR_W-1:0]         r_last_waddr;
    logic [DATA_W-1:0]         r_last_wdata;

    assign w_in_entry = '{result: in_result, rdst1: in_rdst1, rdst2: in_rdst2,
                          wide: in_wide, we: in_we};
    assign w_head     = w_head_bits;
    assign w_push     = in_valid && !w_full;
    assign in_ready   = !w_full;
    assign busy       = !w_empty;
    assign wb_count   = r_count;

    wb_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_in_entry),
        .o_head  (w_head_bits),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Address/data hold their last presented values while the queue is empty.
    always_comb begin
        w_we_raw = 1'b0;
        w_pop    = 1'b0;
        w_waddr  = r_last_waddr;
        w_wdata  = r_last_wdata;
        if (!w_empty) begin
            if (r_phase == S_HI) begin
                w_we_raw = 1'b1;
                w_waddr  = w_head.rdst2;
                w_wdata  = w_head.result[2*DATA_W-1:DATA_W];
                w_pop    = 1'b1;
            end else begin
                w_we_raw = w_head.we;
                w_waddr  = w_head.rdst1;
                w_wdata  = w_head.result[DATA_W-1:0];
                w_pop    = !(w_head.wide && w_head.we);
            end
        end
    end

`ifdef WB_R0_DISCARD_EN
    assign w_we = w_we_raw && (w_waddr != '0);
`else
    assign w_we = w_we_raw;
`endif

    // Masking with rst keeps a drain interrupted by reset from issuing its pending write.
    assign rf_we    = w_we && !rst;
    assign rf_waddr = w_waddr;
    assign rf_wdata = w_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase      <= S_LO;
            r_count      <= '0;
            r_last_waddr <= '0;
            r_last_wdata <= '0;
        end else begin
            if (!w_empty) begin
                r_last_waddr <= w_waddr;
                r_last_wdata <= w_wdata;
            end
            case (r_phase)
                S_LO:    if (!w_empty && w_head.wide && w_head.we) r_phase <= S_HI;
                S_HI:    r_phase <= S_LO;
                default: r_phase <= S_LO;
            endcase
            if (w_pop) r_count <= r_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_writeback_sequencer.sv
// Bench for writeback_sequencer: fixed vector table, corner-case sequences and
// random traffic checked against a queue-of-write-slots reference model.
module tb_writeback_sequencer;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
`ifdef WB_R0_DISCARD_EN
    localparam bit R0_DISCARD = 1'b1;
`else
    localparam bit R0_DISCARD = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2*DW-1:0] in_result;
    logic [AW-1:0] in_rdst1;
    logic [AW-1:0] in_rdst2;
    logic          in_wide;
    logic          in_we;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          busy;
    logic [15:0]   wb_count;

    writeback_sequencer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_rdst1  (in_rdst1),
        .in_rdst2  (in_rdst2),
        .in_wide   (in_wide),
        .in_we     (in_we),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .busy      (busy),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            last;
    } slot_t;

    typedef struct {
        bit            valid;
        logic [31:0]   res;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        bit            wide;
        bit            we;
        bit            e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
        bit            e_busy;
        bit            e_rdy;
        logic [15:0]   e_cnt;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: each accepted entry expands into the write slots it will occupy.
    slot_t         q[$];
    int            n_ent = 0;
    logic [15:0]   m_cnt = '0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    bit            last_acc;
    int            wr_seen = 0;

    vec_t tbl[12];
    vec_t none;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit v, input logic [31:0] res, input logic [AW-1:0] r1,
                          input logic [AW-1:0] r2, input bit wide, input bit we);
        in_valid  = v;
        in_result = res;
        in_rdst1  = r1;
        in_rdst2  = r2;
        in_wide   = wide;
        in_we     = we;
    endtask

    task automatic cycle(input bit has_vec, input vec_t v);
        bit acc;
        bit exp_we;
        acc = 1'b0;
        @(negedge clk);
        if (rst) begin
            chk("rst_rf_we", rf_we, 0);
        end else begin
            exp_we = 1'b0;
            if (q.size() > 0) begin
                exp_we = q[0].we && !(R0_DISCARD && q[0].addr == '0);
                m_addr = q[0].addr;
                m_data = q[0].data;
            end
            if (rf_we) wr_seen++;
            chk("model_rf_we", rf_we, exp_we);
            chk("model_rf_waddr", rf_waddr, m_addr);
            chk("model_rf_wdata", rf_wdata, m_data);
            chk("model_busy", busy, n_ent > 0);
            chk("model_in_ready", in_ready, n_ent < DEPTH);
            chk("model_wb_count", wb_count, m_cnt);
            acc = in_valid && (n_ent < DEPTH);
            if (has_vec) begin
                chk("vec_rf_we", rf_we, v.e_we);
                chk("vec_rf_waddr", rf_waddr, v.e_addr);
                chk("vec_rf_wdata", rf_wdata, v.e_data);
                chk("vec_busy", busy, v.e_busy);
                chk("vec_in_ready", in_ready, v.e_rdy);
                chk("vec_wb_count", wb_count, v.e_cnt);
            end
        end
        @(posedge clk);
        if (rst) begin
            q.delete();
            n_ent  = 0;
            m_cnt  = '0;
            m_addr = '0;
            m_data = '0;
        end else begin
            if (q.size() > 0) begin
                if (q[0].last) begin
                    n_ent--;
                    m_cnt++;
                end
                q.delete(0);
            end
            if (acc) begin
                n_ent++;
                if (in_wide && in_we) begin
                    q.push_back('{in_we, in_rdst1, in_result[DW-1:0], 1'b0});
                    q.push_back('{1'b1, in_rdst2, in_result[2*DW-1:DW], 1'b1});
                end else begin
                    q.push_back('{in_we, in_rdst1, in_result[DW-1:0], 1'b1});
                end
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, '0, '0, '0, 0, 0);
        cycle(0, none);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int guard;
        rst = 1'b1;
        set_in(0, '0, '0, '0, 0, 0);
        none = '{0, '0, '0, '0, 0, 0, 0, '0, '0, 0, 0, '0};

        // valid res r1 r2 wide we | e_we e_addr e_data e_busy e_rdy e_cnt
        tbl[0]  = '{1, 32'h0000_1234, 5'd3, 5'd0, 0, 1,  0, 5'd0, 16'h0000, 0, 1, 16'd0};
        tbl[1]  = '{1, 32'hABCD_5678, 5'd4, 5'd5, 1, 1,  1, 5'd3, 16'h1234, 1, 1, 16'd0};
        tbl[2]  = '{0, 32'h0,         5'd0, 5'd0, 0, 0,  1, 5'd4, 16'h5678, 1, 1, 16'd1};
        tbl[3]  = '{1, 32'h1111_2222, 5'd6, 5'd7, 1, 0,  1, 5'd5, 16'hABCD, 1, 1, 16'd1};
        tbl[4]  = '{0, 32'h0,         5'd0, 5'd0, 0, 0,  0, 5'd6, 16'h2222, 1, 1, 16'd2};
        tbl[5]  = '{1, 32'h0000_0055, 5'd0, 5'd0, 0, 1,  0, 5'd6, 16'h2222, 0, 1, 16'd3};
        tbl[6]  = '{0, 32'h0,         5'd0, 5'd0, 0, 0,  !R0_DISCARD, 5'd0, 16'h0055, 1, 1, 16'd3};
        tbl[7]  = '{0, 32'h0,         5'd0, 5'd0, 0, 0,  0, 5'd0, 16'h0055, 0, 1, 16'd4};
        tbl[8]  = '{1, 32'hBEEF_CAFE, 5'd9, 5'd9, 1, 1,  0, 5'd0, 16'h0055, 0, 1, 16'd4};
        tbl[9]  = '{0, 32'h0,         5'd0, 5'd0, 0, 0,  1, 5'd9, 16'hCAFE, 1, 1, 16'd4};
        tbl[10] = '{0, 32'h0,         5'd0, 5'd0, 0, 0,  1, 5'd9, 16'hBEEF, 1, 1, 16'd4};
        tbl[11] = '{0, 32'h0,         5'd0, 5'd0, 0, 0,  0, 5'd9, 16'hBEEF, 0, 1, 16'd5};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].valid, tbl[i].res, tbl[i].r1, tbl[i].r2, tbl[i].wide, tbl[i].we);
            cycle(1, tbl[i]);
        end

        // Three wide results with valid held: queue fills after two, six writes total.
        do_reset();
        wr_seen = 0;
        k = 0;
        set_in(1, 32'hA000_0A00, 5'd1, 5'd2, 1, 1);
        cycle(0, none);
        if (last_acc) k++;
        set_in(1, 32'hA001_0A01 + 32'(k), 5'd11, 5'd12, 1, 1);
        cycle(0, none);
        if (last_acc) k++;
        chk("wide3_accepts_before_full", k, 2);
        chk("wide3_ready_low", in_ready, 0);
        set_in(1, 32'hA002_0A02, 5'd21, 5'd22, 1, 1);
        guard = 0;
        while (k < 3 && guard < 20) begin
            cycle(0, none);
            if (last_acc) k++;
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while (n_ent > 0 && guard < 20) begin
            cycle(0, none);
            guard++;
        end
        chk("wide3_drain_bound", n_ent, 0);
        cycle(0, none);
        chk("wide3_write_count", wr_seen, 6);
        chk("wide3_retired", wb_count, 3);

        // Reset while the high half is pending.
        do_reset();
        set_in(1, 32'h9999_7777, 5'd10, 5'd11, 1, 1);
        cycle(0, none);
        in_valid = 1'b0;
        cycle(0, none);
        rst = 1'b1;
        #1;
        chk("rst_hi_masked", rf_we, 0);
        cycle(0, none);
        rst = 1'b0;
        chk("rst_hi_busy", busy, 0);
        chk("rst_hi_ready", in_ready, 1);
        chk("rst_hi_rf_waddr", rf_waddr, 0);
        chk("rst_hi_rf_wdata", rf_wdata, 0);
        wr_seen = 0;
        for (int i = 0; i < 4; i++) cycle(0, none);
        chk("rst_hi_no_writes", wr_seen, 0);

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 4) != 0);
            if (i == 200) do_reset();
            else cycle(0, none);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle(0, none);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
